// File: rtl/axi_stream_fifo.sv
// Single-clock AXI4-Stream FIFO, first-word-fall-through read side.
// Carries tvalid/tready/tdata only; count/full/empty come from a registered
// occupancy counter so both ready and valid are free of combinational paths
// from the opposite side of the FIFO.
module axi_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  push;
  logic                  pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign s_tready = !full && !areset;
  assign m_tvalid = !empty && !areset;
  assign m_tdata  = mem[rd_ptr];

  assign push = s_tvalid && s_tready;
  assign pop  = m_tvalid && m_tready;

  // Storage write; not reset, contents are discarded via the pointers.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // Read/write pointers, wrapping naturally at DEPTH.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy counter: +1 on push only, -1 on pop only.
  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Scoreboard bench for axi_stream_fifo: the driver queues every accepted word,
// a monitor pops and compares on every output handshake.
module tb_axi_stream_fifo;

  localparam int DW = 32;
  localparam int DP = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [4:0]    count;
  logic          full;
  logic          empty;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];

  axi_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: inputs only change just after posedge, so negedge shows the handshake of the coming edge.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", m_tdata, 'x);
      end else begin
        chk("m_tdata", m_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // One cycle with s_tvalid as currently driven; queue the word if accepted.
  task automatic cycle_push();
    logic r;
    @(negedge aclk);
    r = s_tvalid && s_tready;
    step();
    if (r) exp_q.push_back(s_tdata);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    logic done;
    done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      done = s_tready;
      step();
    end
    if (done) exp_q.push_back(d);
    else chk("push_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 64 && !empty; i++) step();
    m_tready = 1'b0;
    chk("drain_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;

    // 1. reset and idle
    step(); step();
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    areset = 1'b0;
    step();
    chk("idle_s_tready", {31'd0, s_tready}, 32'd1);
    chk("idle_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("idle_empty",    {31'd0, empty},    32'd1);
    chk("idle_full",     {31'd0, full},     32'd0);
    chk("idle_count",    {27'd0, count},    32'd0);

    // 2. three words, then read back in order
    push_word(32'h11);
    chk("t2_tvalid_latency", {31'd0, m_tvalid}, 32'd1);
    chk("t2_head", m_tdata, 32'h11);
    push_word(32'h22);
    push_word(32'h33);
    chk("t2_count3", {27'd0, count}, 32'd3);
    m_tready = 1'b1;
    chk("t2_d0", m_tdata, 32'h11); step();
    chk("t2_d1", m_tdata, 32'h22); step();
    chk("t2_d2", m_tdata, 32'h33); step();
    m_tready = 1'b0;
    chk("t2_empty", {31'd0, empty}, 32'd1);
    chk("t2_m_tvalid", {31'd0, m_tvalid}, 32'd0);

    // 3. fill to 16, 17th word held until one pop
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_s_tready", {31'd0, s_tready}, 32'd0);
    chk("t3_count16", {27'd0, count}, 32'd16);
    chk("t3_head", m_tdata, 32'd0);
    s_tvalid = 1'b1; s_tdata = 32'd16;
    cycle_push();
    cycle_push();
    chk("t3_held_count", {27'd0, count}, 32'd16);
    m_tready = 1'b1;
    cycle_push();
    m_tready = 1'b0;
    chk("t3_after_pop", {27'd0, count}, 32'd15);
    chk("t3_head_after_pop", m_tdata, 32'd1);
    cycle_push();
    chk("t3_17th_taken", {27'd0, count}, 32'd16);
    s_tvalid = 1'b0;
    drain();

    // 4. streaming 40 words, occupancy stays at one, pointers wrap
    s_tvalid = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_tdata = 32'h100 + DW'(i);
      cycle_push();
      chk("t4_count1", {27'd0, count}, 32'd1);
      chk("t4_no_gap", {31'd0, m_tvalid}, 32'd1);
    end
    s_tvalid = 1'b0;
    step();
    m_tready = 1'b0;
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // 5. full with both sides active: pop only, then push+pop
    for (int i = 0; i < 16; i++) push_word(32'h200 + DW'(i));
    chk("t5_full", {31'd0, full}, 32'd1);
    s_tvalid = 1'b1; s_tdata = 32'h300; m_tready = 1'b1;
    cycle_push();
    chk("t5_pop_only", {27'd0, count}, 32'd15);
    s_tdata = 32'h301;
    cycle_push();
    chk("t5_push_pop", {27'd0, count}, 32'd15);
    s_tvalid = 1'b0; m_tready = 1'b0;
    drain();

    // 6. reset with five words stored
    for (int i = 0; i < 5; i++) push_word(32'h400 + DW'(i));
    chk("t6_count5", {27'd0, count}, 32'd5);
    areset = 1'b1;
    step();
    exp_q.delete();
    areset = 1'b0;
    chk("t6_count0", {27'd0, count}, 32'd0);
    chk("t6_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    push_word(32'hA5);
    chk("t6_a5_valid", {31'd0, m_tvalid}, 32'd1);
    chk("t6_a5_data", m_tdata, 32'hA5);
    chk("t6_count1", {27'd0, count}, 32'd1);
    drain();

    step();
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
